// File: rtl/spi_gpio_hub_pkg.sv
// Shared constants for the SPI-to-GPIO hub: register map, command byte layout, FSM states.
package spi_gpio_hub_pkg;

   // Per-port register offsets within a 4-byte port block
   localparam logic [1:0] OFF_OE    = 2'd0;
   localparam logic [1:0] OFF_ODATA = 2'd1;
   localparam logic [1:0] OFF_IDATA = 2'd2;
   localparam logic [1:0] OFF_ISR   = 2'd3;

   localparam logic [5:0] IER_BASE   = 6'h30;
   localparam logic [5:0] ID_ADDR    = 6'h3F;
   localparam logic [7:0] ID_VALUE   = 8'hA5;
   localparam logic [7:0] DUMMY_BYTE = 8'h5A;

   // Command byte layout: [7] write, [6] auto-increment, [5:0] start address
   localparam int unsigned CMD_WR_BIT   = 7;
   localparam int unsigned CMD_AINC_BIT = 6;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode 0 slave front end: input synchronisers, SCK/CS edge detect, bit counter,
// receive and transmit shift registers. Everything runs in the system clock domain.
module spi_slave_shifter
   import spi_gpio_hub_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   input  logic       load,
   input  logic [7:0] load_data,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   output logic       cs_fall,
   output logic       cs_rise,
   output logic       miso,
   output logic       miso_oe
);

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_prev, cs_prev;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall;
   logic                   frame_ok;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_sr, tx_sr;

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign cs_fall  = ~cs_s & cs_prev;
   assign cs_rise  = cs_s & ~cs_prev;
   assign miso_oe  = frame_ok & ~cs_s;

   // Synchronisers and edge-detect history. CS resets to "low" so a frame that is already
   // in progress when reset lifts never shows a falling edge and stays ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
      end
   end

   // Frame tracking, bit counting and both shift registers
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_ok  <= 1'b0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         rx_byte   <= '0;
         byte_done <= 1'b0;
         tx_sr     <= '0;
         miso      <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (cs_fall) begin
            frame_ok <= 1'b1;
            bit_cnt  <= '0;
            // MSB of the dummy byte must be on the pad before the first SCK rise
            miso     <= DUMMY_BYTE[7];
            tx_sr    <= {DUMMY_BYTE[6:0], 1'b0};
         end else if (cs_rise) begin
            frame_ok <= 1'b0;
            bit_cnt  <= '0;
         end else if (frame_ok && !cs_s) begin
            if (sck_rise) begin
               rx_sr   <= {rx_sr[6:0], mosi_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_done <= 1'b1;
                  rx_byte   <= {rx_sr[6:0], mosi_s};
               end
            end
            // tx_sr holds the bits not yet presented; a load lands between the 8th rise and
            // the following fall, so that fall presents the new byte's MSB.
            if (load) begin
               tx_sr <= load_data;
            end else if (sck_fall) begin
               miso  <= tx_sr[7];
               tx_sr <= {tx_sr[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/spi_gpio_hub.sv
// SPI-controlled GPIO hub: per-port OE/ODATA/IDATA registers behind a byte-addressed SPI
// register interface. Define SPI_GPIO_HUB_IRQ_EN to build input edge interrupts (ISR/IER/o_irq).
module spi_gpio_hub
   import spi_gpio_hub_pkg::*;
#(
   parameter int unsigned N_PORTS     = 4,
   parameter int unsigned PORT_W      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_spi_clk,
   input  logic                        i_spi_cs_n,
   input  logic                        i_spi_mosi,
   output logic                        o_spi_miso,
   output logic                        o_spi_miso_oe,
   output logic [N_PORTS*PORT_W-1:0]   o_gpio_out,
   output logic [N_PORTS*PORT_W-1:0]   o_gpio_oe,
   input  logic [N_PORTS*PORT_W-1:0]   i_gpio_in,
   output logic                        o_irq
);

   localparam int unsigned W = N_PORTS * PORT_W;

   logic                            byte_done, cs_fall, cs_rise;
   logic [7:0]                      rx_byte, rd_data;
   state_t                          state_q;
   logic [5:0]                      addr_q;
   logic                            wr_q, ainc_q, load_q, wr_en;
   logic [SYNC_STAGES-1:0][W-1:0]   gin_sync;
   logic [N_PORTS-1:0][PORT_W-1:0]  idata;
   logic [N_PORTS-1:0][PORT_W-1:0]  oe_q, oe_d, odata_q, odata_d;
`ifdef SPI_GPIO_HUB_IRQ_EN
   logic [N_PORTS-1:0][PORT_W-1:0]  isr_q, isr_d, ier_q, ier_d, idata_prev;
   logic                            irq_q;
`endif

   spi_slave_shifter #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_shifter (
      .clk       (i_clk),
      .rst       (i_rst),
      .spi_clk   (i_spi_clk),
      .spi_cs_n  (i_spi_cs_n),
      .spi_mosi  (i_spi_mosi),
      .load      (load_q),
      .load_data (rd_data),
      .byte_done (byte_done),
      .rx_byte   (rx_byte),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .miso      (o_spi_miso),
      .miso_oe   (o_spi_miso_oe)
   );

   assign idata      = gin_sync[SYNC_STAGES-1];
   assign o_gpio_oe  = oe_q;
   assign o_gpio_out = odata_q;
   assign wr_en      = byte_done && (state_q == DATA) && wr_q;

   // Frame FSM: decode the command byte, step the address, request transmit loads on reads
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         ainc_q  <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         load_q <= 1'b0;
         if (cs_rise) begin
            state_q <= IDLE;
         end else if (cs_fall) begin
            state_q <= CMD;
         end else if (byte_done) begin
            case (state_q)
               CMD: begin
                  wr_q    <= rx_byte[CMD_WR_BIT];
                  ainc_q  <= rx_byte[CMD_AINC_BIT];
                  addr_q  <= rx_byte[5:0];
                  load_q  <= ~rx_byte[CMD_WR_BIT];
                  state_q <= DATA;
               end
               DATA: begin
                  if (ainc_q) addr_q <= addr_q + 6'd1;
                  load_q <= ~wr_q;
               end
               default: ;
            endcase
         end
      end
   end

   // Read mux; anything unmapped or beyond N_PORTS reads as zero
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (addr_q[5:2] == 4'(p)) begin
            if (addr_q[1:0] == OFF_OE)    rd_data[PORT_W-1:0] = oe_q[p];
            if (addr_q[1:0] == OFF_ODATA) rd_data[PORT_W-1:0] = odata_q[p];
            if (addr_q[1:0] == OFF_IDATA) rd_data[PORT_W-1:0] = idata[p];
`ifdef SPI_GPIO_HUB_IRQ_EN
            if (addr_q[1:0] == OFF_ISR)   rd_data[PORT_W-1:0] = isr_q[p];
`endif
         end
`ifdef SPI_GPIO_HUB_IRQ_EN
         if (addr_q == IER_BASE + 6'(p)) rd_data[PORT_W-1:0] = ier_q[p];
`endif
      end
      if (addr_q == ID_ADDR) rd_data = ID_VALUE;
   end

   // Register writes; ISR edge-set is applied after W1C so a same-cycle set wins
   always_comb begin
      oe_d    = oe_q;
      odata_d = odata_q;
`ifdef SPI_GPIO_HUB_IRQ_EN
      isr_d   = isr_q;
      ier_d   = ier_q;
`endif
      if (wr_en) begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (addr_q[5:2] == 4'(p)) begin
               if (addr_q[1:0] == OFF_OE)    oe_d[p]    = rx_byte[PORT_W-1:0];
               if (addr_q[1:0] == OFF_ODATA) odata_d[p] = rx_byte[PORT_W-1:0];
`ifdef SPI_GPIO_HUB_IRQ_EN
               if (addr_q[1:0] == OFF_ISR)   isr_d[p]   = isr_q[p] & ~rx_byte[PORT_W-1:0];
`endif
            end
`ifdef SPI_GPIO_HUB_IRQ_EN
            if (addr_q == IER_BASE + 6'(p)) ier_d[p] = rx_byte[PORT_W-1:0];
`endif
         end
      end
`ifdef SPI_GPIO_HUB_IRQ_EN
      isr_d = isr_d | (idata & ~idata_prev & ier_q);
`endif
   end

   // GPIO input synchroniser and register state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gin_sync   <= '0;
         oe_q       <= '0;
         odata_q    <= '0;
`ifdef SPI_GPIO_HUB_IRQ_EN
         isr_q      <= '0;
         ier_q      <= '0;
         idata_prev <= '0;
         irq_q      <= 1'b0;
`endif
      end else begin
         gin_sync   <= {gin_sync[SYNC_STAGES-2:0], i_gpio_in};
         oe_q       <= oe_d;
         odata_q    <= odata_d;
`ifdef SPI_GPIO_HUB_IRQ_EN
         isr_q      <= isr_d;
         ier_q      <= ier_d;
         idata_prev <= idata;
         irq_q      <= |(isr_q & ier_q);
`endif
      end
   end

`ifdef SPI_GPIO_HUB_IRQ_EN
   assign o_irq = irq_q;
`else
   assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_gpio_hub.sv
// Self-checking bench for spi_gpio_hub: SPI master tasks with a MISO scoreboard plus
// direct checks of GPIO outputs, interrupt and reset behaviour.
module tb_spi_gpio_hub;

   localparam int HALF = 8;  // SCK half period in i_clk cycles
`ifdef SPI_GPIO_HUB_IRQ_EN
   localparam logic [7:0] IRQ_ON = 8'h01;
`else
   localparam logic [7:0] IRQ_ON = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic [31:0] gpio_in = '0;
   logic        miso, miso_oe, irq;
   logic [31:0] gpio_out, gpio_oe;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   spi_gpio_hub dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_spi_clk     (spi_clk),
      .i_spi_cs_n    (spi_cs_n),
      .i_spi_mosi    (spi_mosi),
      .o_spi_miso    (miso),
      .o_spi_miso_oe (miso_oe),
      .o_gpio_out    (gpio_out),
      .o_gpio_oe     (gpio_oe),
      .i_gpio_in     (gpio_in),
      .o_irq         (irq)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SPI mode 0 byte (or partial byte); the expected MISO byte is queued before shifting
   task automatic spi_byte(input logic [7:0] tx, input bit chk, input logic [7:0] exp,
                           input int nbits);
      logic [7:0] rx = '0;
      logic [7:0] e;
      if (chk) exp_q.push_back(exp);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         wait_clk(HALF);
         spi_clk = 1'b1;
         rx = {rx[6:0], miso};
         wait_clk(HALF);
         spi_clk = 1'b0;
      end
      if (chk) begin
         e = exp_q.pop_front();
         check_val("miso_byte", 32'(rx), 32'(e));
      end
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      wait_clk(4);
      check_val("miso_oe_active", 32'(miso_oe), 32'd1);
   endtask

   task automatic cs_high();
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(8);
      check_val("miso_oe_idle", 32'(miso_oe), 32'd0);
   endtask

   // Full frame of n bytes; command byte always returns the dummy, data bytes checked if rd
   task automatic frame(input int n, input logic [7:0] c, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input bit rd,
                        input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] tx[4];
      logic [7:0] ex[4];
      tx[0] = c;     tx[1] = d1; tx[2] = d2; tx[3] = d3;
      ex[0] = 8'h5A; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      cs_low();
      for (int i = 0; i < n; i++) spi_byte(tx[i], (i == 0) || rd, ex[i], 8);
      cs_high();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      wait_clk(5);
      check_val("rst_gpio_out", gpio_out, 32'h0);
      check_val("rst_gpio_oe", gpio_oe, 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      check_val("rst_miso", 32'(miso), 32'h0);
      check_val("rst_miso_oe", 32'(miso_oe), 32'h0);
      rst = 1'b0;
      gpio_in = 32'h0000_0096;
      wait_clk(10);

      // Writes to OE0 and ODATA0
      frame(2, 8'h80, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      frame(2, 8'h81, 8'h3C, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("oe0_ff", gpio_oe[7:0], 32'hFF);
      check_val("out0_3c", gpio_out[7:0], 32'h3C);

      // Read burst with auto-increment from address 0
      frame(2, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      frame(4, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h3C, 8'h96);

      // Auto-increment write at 0x3F wraps to 0x00; ID stays intact
      frame(3, 8'hFF, 8'h11, 8'h22, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("oe0_wrap", gpio_oe[7:0], 32'h22);
      frame(2, 8'h3F, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h00, 8'h00);

      // Highest port, then out-of-range port and read-only IDATA writes
      frame(3, 8'hCC, 8'hA1, 8'hB2, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("oe3", gpio_oe[31:24], 32'hA1);
      check_val("out3", gpio_out[31:24], 32'hB2);
      frame(2, 8'h90, 8'h77, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      frame(2, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
      frame(2, 8'h82, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      frame(3, 8'h42, 8'h00, 8'h00, 8'h00, 1'b1, 8'h96, 8'h00, 8'h00);

      // Interrupt: enable bit 0, raise input bit 0, then clear with W1C
      frame(2, 8'hB0, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      gpio_in = 32'h0000_0097;
      wait_clk(10);
      check_val("irq_set", 32'(irq), 32'(IRQ_ON[0]));
      frame(2, 8'h30, 8'h00, 8'h00, 8'h00, 1'b1, IRQ_ON, 8'h00, 8'h00);
      frame(2, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, IRQ_ON, 8'h00, 8'h00);
      frame(2, 8'h83, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("irq_clr", 32'(irq), 32'h0);
      frame(2, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);

      // CS rise after 5 bits of a data byte discards it
      cs_low();
      spi_byte(8'h85, 1'b1, 8'h5A, 8);
      spi_byte(8'hEE, 1'b0, 8'h00, 5);
      cs_high();
      check_val("out1_partial", gpio_out[15:8], 32'h00);
      frame(2, 8'h85, 8'h5C, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("out1_next", gpio_out[15:8], 32'h5C);

      // Reset mid-burst: outputs clear and the rest of the frame is ignored
      cs_low();
      spi_byte(8'hC0, 1'b1, 8'h5A, 8);
      spi_byte(8'h12, 1'b0, 8'h00, 8);
      wait_clk(4);
      check_val("oe0_pre_rst", gpio_oe[7:0], 32'h12);
      rst = 1'b1;
      wait_clk(3);
      check_val("mid_rst_out", gpio_out, 32'h0);
      check_val("mid_rst_oe", gpio_oe, 32'h0);
      check_val("mid_rst_irq", 32'(irq), 32'h0);
      check_val("mid_rst_miso", 32'(miso), 32'h0);
      check_val("mid_rst_miso_oe", 32'(miso_oe), 32'h0);
      rst = 1'b0;
      wait_clk(4);
      spi_byte(8'h80, 1'b0, 8'h00, 8);
      spi_byte(8'h77, 1'b0, 8'h00, 8);
      wait_clk(4);
      check_val("post_rst_oe", gpio_oe, 32'h0);
      check_val("post_rst_miso_oe", 32'(miso_oe), 32'h0);
      cs_high();
      frame(2, 8'h80, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      check_val("after_rst_oe", gpio_oe, 32'h0000_000F);
      check_val("after_rst_out", gpio_out, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
